// File: rtl/comperator_axi_ip_v1_0_sad_matcher_if.sv
`default_nettype none
// ============================================================================
// Module   : comperator_axi_ip_v1_0_sad_matcher_if
// Purpose  : Bundles the reference/candidate block inputs and the result
//            outputs of the SAD disparity matcher.
//   ref_block/ref_load            : reference block and its capture strobe
//   cand_block/cand_valid/
//   cand_last/cand_ready          : candidate handshake, cand_last ends search
//   result_valid/disparity/
//   min_sad/busy                  : search result and activity flag
// Modports : master = block-reader side, slave = matcher side.
// Revision : 1.0 - initial release
// ============================================================================
interface comperator_axi_ip_v1_0_sad_matcher_if #(
    parameter int BLOCK_SIZE = 8
);
    localparam int BLOCK_WIDTH = BLOCK_SIZE * 24;

    logic [BLOCK_WIDTH-1:0] ref_block;
    logic                   ref_load;
    logic [BLOCK_WIDTH-1:0] cand_block;
    logic                   cand_valid;
    logic                   cand_last;
    logic                   cand_ready;
    logic                   result_valid;
    logic [7:0]             disparity;
    logic [15:0]            min_sad;
    logic                   busy;

    modport master (
        output ref_block, ref_load, cand_block, cand_valid, cand_last,
        input  cand_ready, result_valid, disparity, min_sad, busy
    );

    modport slave (
        input  ref_block, ref_load, cand_block, cand_valid, cand_last,
        output cand_ready, result_valid, disparity, min_sad, busy
    );
endinterface
`default_nettype wire

// File: rtl/comperator_axi_ip_v1_0_sad_matcher.sv
`default_nettype none
// ============================================================================
// Module   : comperator_axi_ip_v1_0_sad_matcher
// Purpose  : Latches one reference block, then scores a sequence of candidate
//            blocks by serial sum of absolute differences (one pixel per
//            cycle, three 8-bit channels per pixel) and reports the index of
//            the lowest-SAD candidate.
// Ports    : aclk   - clock, rising edge
//            areset - asynchronous active-high reset
//            bus    - slave side of the matcher interface
// Revision : 1.0 - initial release
// ============================================================================
module comperator_axi_ip_v1_0_sad_matcher #(
    parameter int BLOCK_SIZE    = 8,
    parameter int MAX_DISPARITY = 16
) (
    input  wire logic aclk,
    input  wire logic areset,
    comperator_axi_ip_v1_0_sad_matcher_if.slave bus
);
    localparam int DATA_WIDTH = 24;
    localparam int PIX_W      = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;

    localparam logic [PIX_W-1:0] c_last_pix = PIX_W'(BLOCK_SIZE - 1);
    localparam logic [7:0]       c_last_idx = 8'(MAX_DISPARITY - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        READY  = 3'd1,
        ACCUM  = 3'd2,
        UPDATE = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] r_ref;
    logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] r_cand;
    logic [PIX_W-1:0] r_pix_cnt;
    logic [15:0]      r_acc;
    logic [15:0]      r_best_sad;
    logic [7:0]       r_best_idx;
    logic [7:0]       r_cand_idx;
    logic             r_last;

    logic             r_cand_ready;
    logic             r_result_valid;
    logic             r_busy;
    logic [7:0]       r_disparity;
    logic [15:0]      r_min_sad;

    function automatic logic [7:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    logic [DATA_WIDTH-1:0] w_ref_pix;
    logic [DATA_WIDTH-1:0] w_cand_pix;
    logic [9:0]            w_pix_sad;
    logic                  w_better;
    logic [15:0]           w_upd_sad;
    logic [7:0]            w_upd_idx;

    assign w_ref_pix  = r_ref[r_pix_cnt];
    assign w_cand_pix = r_cand[r_pix_cnt];
    assign w_pix_sad  = {2'b00, abs_diff(w_ref_pix[7:0],   w_cand_pix[7:0])}
                      + {2'b00, abs_diff(w_ref_pix[15:8],  w_cand_pix[15:8])}
                      + {2'b00, abs_diff(w_ref_pix[23:16], w_cand_pix[23:16])};

    // Strict compare keeps the earlier (lower) index on a tie.
    assign w_better  = (r_acc < r_best_sad);
    assign w_upd_sad = w_better ? r_acc      : r_best_sad;
    assign w_upd_idx = w_better ? r_cand_idx : r_best_idx;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.ref_load)            w_next = READY;
            READY:   if (bus.cand_valid)          w_next = ACCUM;
            ACCUM:   if (r_pix_cnt == c_last_pix) w_next = UPDATE;
            UPDATE:  w_next = (r_last || (r_cand_idx == c_last_idx)) ? DONE : READY;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Status outputs are decoded from the next state so that the registered
    // flag always matches the state register it accompanies.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_cand_ready   <= 1'b0;
            r_result_valid <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_cand_ready   <= (w_next == READY);
            r_result_valid <= (w_next == DONE);
            r_busy         <= (w_next != IDLE);
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_ref       <= '0;
            r_cand      <= '0;
            r_pix_cnt   <= '0;
            r_acc       <= '0;
            r_best_sad  <= 16'hFFFF;
            r_best_idx  <= '0;
            r_cand_idx  <= '0;
            r_last      <= 1'b0;
            r_disparity <= '0;
            r_min_sad   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.ref_load) begin
                        r_ref      <= bus.ref_block;
                        r_cand_idx <= '0;
                        r_best_sad <= 16'hFFFF;
                        r_best_idx <= '0;
                    end
                end
                READY: begin
                    if (bus.cand_valid) begin
                        r_cand    <= bus.cand_block;
                        r_last    <= bus.cand_last;
                        r_pix_cnt <= '0;
                        r_acc     <= '0;
                    end
                end
                ACCUM: begin
                    r_acc     <= r_acc + {6'd0, w_pix_sad};
                    r_pix_cnt <= r_pix_cnt + PIX_W'(1);
                end
                UPDATE: begin
                    r_best_sad <= w_upd_sad;
                    r_best_idx <= w_upd_idx;
                    if (w_next == DONE) begin
                        // Publish the post-update winner; it holds until the next DONE.
                        r_disparity <= w_upd_idx;
                        r_min_sad   <= w_upd_sad;
                    end else begin
                        r_cand_idx <= r_cand_idx + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.cand_ready   = r_cand_ready;
    assign bus.result_valid = r_result_valid;
    assign bus.busy         = r_busy;
    assign bus.disparity    = r_disparity;
    assign bus.min_sad      = r_min_sad;
endmodule
`default_nettype wire

// File: tb/tb_comperator_axi_ip_v1_0_sad_matcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_comperator_axi_ip_v1_0_sad_matcher
// Purpose  : Directed self-checking bench for the SAD disparity matcher.
// Revision : 1.0 - initial release
// ============================================================================
module tb_comperator_axi_ip_v1_0_sad_matcher;
    localparam int BLOCK_SIZE    = 8;
    localparam int MAX_DISPARITY = 16;
    localparam int BW            = BLOCK_SIZE * 24;

    logic aclk   = 1'b0;
    logic areset = 1'b1;

    comperator_axi_ip_v1_0_sad_matcher_if #(.BLOCK_SIZE(BLOCK_SIZE)) bus ();

    comperator_axi_ip_v1_0_sad_matcher #(
        .BLOCK_SIZE   (BLOCK_SIZE),
        .MAX_DISPARITY(MAX_DISPARITY)
    ) u_dut (
        .aclk  (aclk),
        .areset(areset),
        .bus   (bus)
    );

    always #5 aclk = ~aclk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    function automatic logic [BW-1:0] fill(input logic [23:0] px);
        logic [BW-1:0] b;
        for (int i = 0; i < BLOCK_SIZE; i++) b[i*24 +: 24] = px;
        return b;
    endfunction

    task automatic load_ref(input logic [BW-1:0] blk);
        bus.ref_block = blk;
        bus.ref_load  = 1'b1;
        step();
        bus.ref_load  = 1'b0;
        check_val("load_ready", bus.cand_ready, 1);
        check_val("load_busy", bus.busy, 1);
    endtask

    // Entered in a READY cycle at posedge+1; returns at accept+BLOCK_SIZE+2.
    task automatic send_cand(input string tag, input logic [BW-1:0] blk, input logic last,
                             input logic done, input logic [7:0] exp_disp,
                             input logic [15:0] exp_sad, input int stall);
        logic ok;
        ok = 1'b1;
        bus.cand_valid = 1'b0;
        for (int i = 0; i < stall; i++) begin
            bus.cand_block = ~blk;
            step();
            if (!(bus.cand_ready === 1'b1 && bus.busy === 1'b1 && bus.result_valid === 1'b0))
                ok = 1'b0;
        end
        if (stall > 0) check_val({tag, "_stall"}, ok, 1);
        bus.cand_block = blk;
        bus.cand_valid = 1'b1;
        bus.cand_last  = last;
        step();
        bus.cand_valid = 1'b0;
        bus.cand_last  = 1'b0;
        bus.cand_block = ~blk;
        check_val({tag, "_ready_drop"}, bus.cand_ready, 0);
        ok = 1'b1;
        repeat (BLOCK_SIZE + 1) begin
            if (bus.result_valid !== 1'b0 || bus.cand_ready !== 1'b0) ok = 1'b0;
            step();
        end
        check_val({tag, "_quiet"}, ok, 1);
        if (done) begin
            check_val({tag, "_rv"}, bus.result_valid, 1);
            check_val({tag, "_disp"}, bus.disparity, exp_disp);
            check_val({tag, "_sad"}, bus.min_sad, exp_sad);
        end else begin
            check_val({tag, "_ready_back"}, bus.cand_ready, 1);
            check_val({tag, "_no_rv"}, bus.result_valid, 0);
        end
    endtask

    initial begin
        logic [BW-1:0] blk;
        logic ok;
        bus.ref_block  = '0;
        bus.ref_load   = 1'b0;
        bus.cand_block = '0;
        bus.cand_valid = 1'b0;
        bus.cand_last  = 1'b0;

        repeat (2) @(posedge aclk);
        #1;
        check_val("rst_ready", bus.cand_ready, 0);
        check_val("rst_rv", bus.result_valid, 0);
        check_val("rst_busy", bus.busy, 0);
        check_val("rst_disp", bus.disparity, 0);
        check_val("rst_sad", bus.min_sad, 0);
        areset = 1'b0;
        step();

        // cand_valid has no effect while idle
        bus.cand_valid = 1'b1;
        step();
        step();
        check_val("idle_ign_busy", bus.busy, 0);
        check_val("idle_ign_ready", bus.cand_ready, 0);
        bus.cand_valid = 1'b0;

        // Identical blocks, single candidate
        load_ref(fill(24'h102030));
        send_cand("ident", fill(24'h102030), 1'b1, 1'b1, 8'd0, 16'd0, 0);
        bus.ref_load = 1'b1;             // coincides with DONE: ignored
        step();
        bus.ref_load = 1'b0;
        check_val("done_load_busy", bus.busy, 0);
        check_val("done_load_ready", bus.cand_ready, 0);
        step();

        // Minimum at index 2: SAD 72, 48, 0, 24
        load_ref(fill(24'h102030));
        send_cand("min0", fill(24'h132333), 1'b0, 1'b0, 8'd0, 16'd0, 0);
        send_cand("min1", fill(24'h122232), 1'b0, 1'b0, 8'd0, 16'd0, 0);
        send_cand("min2", fill(24'h102030), 1'b0, 1'b0, 8'd0, 16'd0, 0);
        send_cand("min3", fill(24'h112131), 1'b1, 1'b1, 8'd2, 16'd0, 0);
        step();

        // Same search with 5-cycle upstream stalls
        load_ref(fill(24'h102030));
        send_cand("bp0", fill(24'h132333), 1'b0, 1'b0, 8'd0, 16'd0, 5);
        send_cand("bp1", fill(24'h122232), 1'b0, 1'b0, 8'd0, 16'd0, 5);
        send_cand("bp2", fill(24'h102030), 1'b0, 1'b0, 8'd0, 16'd0, 5);
        send_cand("bp3", fill(24'h112131), 1'b1, 1'b1, 8'd2, 16'd0, 5);
        step();

        // Extremes, no cand_last: forced completion after 16 candidates
        load_ref(fill(24'h000000));
        for (int i = 0; i < MAX_DISPARITY; i++)
            send_cand("sat", fill(24'hFFFFFF), 1'b0, (i == MAX_DISPARITY - 1), 8'd0, 16'd6120, 0);
        bus.cand_valid = 1'b1;
        ok = 1'b1;
        repeat (4) begin
            step();
            if (bus.cand_ready !== 1'b0 || bus.busy !== 1'b0) ok = 1'b0;
        end
        check_val("sat_ready_low", ok, 1);
        bus.cand_valid = 1'b0;

        // Tie: SAD 48, 24, 24 keeps index 1
        load_ref(fill(24'h102030));
        send_cand("tie0", fill(24'h122232), 1'b0, 1'b0, 8'd0, 16'd0, 0);
        send_cand("tie1", fill(24'h0F1F2F), 1'b0, 1'b0, 8'd0, 16'd0, 0);
        send_cand("tie2", fill(24'h112131), 1'b1, 1'b1, 8'd1, 16'd24, 0);
        step();
        check_val("hold_rv", bus.result_valid, 0);
        check_val("hold_disp", bus.disparity, 1);
        check_val("hold_sad", bus.min_sad, 24);

        // Asynchronous reset in the middle of accumulation
        load_ref(fill(24'h102030));
        bus.cand_block = fill(24'h132333);
        bus.cand_valid = 1'b1;
        bus.cand_last  = 1'b1;
        step();
        bus.cand_valid = 1'b0;
        bus.cand_last  = 1'b0;
        step();
        step();
        #2 areset = 1'b1;
        #1;
        check_val("arst_ready", bus.cand_ready, 0);
        check_val("arst_busy", bus.busy, 0);
        check_val("arst_rv", bus.result_valid, 0);
        check_val("arst_disp", bus.disparity, 0);
        check_val("arst_sad", bus.min_sad, 0);
        #3 areset = 1'b0;
        ok = 1'b1;
        repeat (12) begin
            step();
            if (bus.result_valid !== 1'b0 || bus.busy !== 1'b0) ok = 1'b0;
        end
        check_val("arst_quiet", ok, 1);

        // Full search after reset, per-pixel/per-channel differences: SAD 72, 10, 5
        load_ref(fill(24'h102030));
        send_cand("post0", fill(24'h132333), 1'b0, 1'b0, 8'd0, 16'd0, 0);
        blk = fill(24'h102030);
        blk[5*24 +: 24] = 24'h10203A;
        send_cand("post1", blk, 1'b0, 1'b0, 8'd0, 16'd0, 0);
        blk = fill(24'h102030);
        blk[0 +: 24] = 24'h102530;
        send_cand("post2", blk, 1'b1, 1'b1, 8'd2, 16'd5, 0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/comperator_axi_ip_v1_0_sad_matcher.md
# comperator_axi_ip_v1_0_sad_matcher

Disparity matcher that sits directly downstream of the block readers in the stereoscopic comparator IP. It latches one reference block from the left-frame reader. It then accepts a sequence of candidate blocks from the right-frame reader, one per shift. For each candidate it computes the sum of absolute differences (SAD) serially and reports the shift index with the lowest SAD.

## Interface
Parameters:
- BLOCK_SIZE, 8, pixels per block. Must be in 1..85 so that SAD cannot overflow 16 bits.
- MAX_DISPARITY, 16, maximum number of candidates per search. Range 1..256.
- Derived: DATA_WIDTH = 24; BLOCK_WIDTH = BLOCK_SIZE*24.

Ports:
- aclk  in  1  clock. All logic is on the rising edge.
- areset  in  1  reset. One clock; reset is asynchronous and active-high.
- ref_block  in  BLOCK_WIDTH  reference (left) block. Pixel i occupies bits [24i+23:24i]; channels are bytes [7:0], [15:8], [23:16].
- ref_load  in  1  one-cycle strobe that captures ref_block.
- cand_block  in  BLOCK_WIDTH  candidate (right) block, same packing as ref_block.
- cand_valid  in  1  cand_block is valid.
- cand_last  in  1  marks this candidate as the final one of the search. Sampled with cand_valid.
- cand_ready  out  1  matcher can accept a candidate.
- result_valid  out  1  one-cycle pulse; result fields are valid.
- disparity  out  8  index of the best candidate (0-based, in acceptance order).
- min_sad  out  16  SAD of the best candidate.
- busy  out  1  high in every state except IDLE.

## Operation
- **State encoding:** IDLE=0, READY=1, ACCUM=2, UPDATE=3, DONE=4. Unused encodings go to IDLE.
- **IDLE:**
  - On ref_load, register ref_block → READY.
  - Clear cand_idx to 0 and best_sad to 16'hFFFF.
  - cand_valid is ignored in this state.
- **READY:**
  - cand_ready=1.
  - Accept when cand_valid=1: register cand_block, register cand_last into last_r, clear pix_cnt and acc → ACCUM.
  - ref_load is ignored.
- **ACCUM:** one pixel per cycle, pixel pix_cnt.
  - acc += |R_ref−R_cand| + |G_ref−G_cand| + |B_ref−B_cand|. The per-pixel term is 10 bits (max 765); acc is 16 bits.
  - Move to UPDATE after pix_cnt == BLOCK_SIZE−1.
- **UPDATE:**
  - If acc < best_sad (strict), then best_sad ← acc and best_idx ← cand_idx. On a tie, the lower index is kept.
  - If last_r=1 or cand_idx == MAX_DISPARITY−1 → DONE.
  - Otherwise cand_idx += 1 → READY.
- **DONE:**
  - result_valid=1 for exactly this cycle.
  - disparity=best_idx, min_sad=best_sad.
  - → IDLE.
- **Hold behaviour:**
  - disparity and min_sad hold their last values until the next DONE.
  - Internal best_sad/best_idx are re-initialised only on ref_load in IDLE.
- **Forced completion:** a search ends at MAX_DISPARITY candidates even if cand_last was never seen. cand_ready stays low from then until the next search reaches READY.
- **Reset values:** state=IDLE, cand_ready=0, result_valid=0, busy=0, disparity=0, min_sad=0. Internal registers are all 0, except best_sad=16'hFFFF.

## Timing
- **Output decoding:** cand_ready, busy and result_valid are registered decodes of state. No combinational path exists from any input to any output.
- **ref_load:** asserted at cycle T in IDLE gives cand_ready=1 at T+1.
- **Candidate accepted at cycle T:**
  - cand_ready=0 at T+1.
  - ACCUM occupies T+1..T+BLOCK_SIZE.
  - UPDATE at T+BLOCK_SIZE+1.
  - Then either cand_ready=1 or result_valid=1 at T+BLOCK_SIZE+2.
- **Throughput:** one candidate per BLOCK_SIZE+2 cycles when the upstream reader is always valid.
- **Total search latency:** N candidates at full rate take N·(BLOCK_SIZE+2) cycles from the first accept to result_valid. Add 1 cycle of IDLE→READY.
- **Upstream stalls:** cand_valid low in READY causes a stall with no state change. cand_block may change while cand_ready=0.
- **Single-candidate search:** cand_last=1 on the first candidate gives disparity=0 and min_sad equal to that SAD.
- **Asynchronous reset mid-search:** all state clears immediately. No result_valid is emitted, and the next search requires a new ref_load.
- **ref_load coinciding with DONE:** ignored. The next ref_load must arrive in IDLE.

## Test plan
- **Identical blocks:** BLOCK_SIZE=8, MAX_DISPARITY=16, ref = cand = all 24'h102030, cand_last on the first candidate → result_valid at accept+10 with disparity=0 and min_sad=0.
- **Minimum at a known index:** 4 candidates whose every channel differs from ref by 3, 2, 0, 1 respectively (per block: 72, 48, 0, 24), cand_last on the 4th → disparity=2, min_sad=0.
- **Tie resolution:** candidates with SAD 48, 24, 24 → disparity=1, min_sad=24.
- **Saturation extremes and forced completion:** ref all 24'h000000, candidates all 24'hFFFFFF (SAD 6120 each), cand_last never asserted → result after exactly 16 candidates with disparity=0 and min_sad=6120; cand_ready stays 0 afterwards until a new ref_load.
- **Backpressure:** cand_valid held low for 5 cycles in READY, then asserted → no state change during the stall, accumulation begins the cycle after the accept, and the result is unchanged versus the no-stall run.
- **Reset mid-ACCUM:** assert areset asynchronously between edges in ACCUM → outputs are immediately at their reset values, no result_valid occurs, and a subsequent full search returns a correct result.
